fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, sitting directly upstream of the IF/ID boundary.
- Owns the PC/nPC pair using delay-slot semantics: PC <= nPC, nPC <= nPC+4.
- Drives the instruction-memory address and registers the fetched word plus its PC into the IF/ID outputs.
- Accepts stall controls from the hazard/forwarding unit and redirect requests (branch/jump target) from ID.
- A redirect that arrives during a stall is buffered until the stall releases.

Parameters:
IMEM_AW, 9, instruction-memory address width (low bits of PC)
RESET_PC, 32'd0, PC value after reset (nPC resets to RESET_PC+4)
CNT_W, 16, width of performance counters

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
pc_enable  input  1  hazard unit: 1 = PC/nPC may advance
load_enable  input  1  hazard unit: 1 = IF/ID outputs may load
nop_signal  input  1  hazard unit: load a bubble (instr 0, valid 0) instead of fetched word
branch_taken  input  1  ID: redirect request, single-cycle pulse
target_addr  input  32  ID: redirect target, sampled with branch_taken
imem_addr  output  IMEM_AW  instruction-memory address = pc[IMEM_AW-1:0]
imem_data  input  32  instruction word (combinational read of imem_addr)
pc  output  32  current PC
npc  output  32  current nPC
ifid_instruction  output  32  registered instruction to ID
ifid_pc  output  32  registered PC of that instruction
ifid_valid  output  1  1 = ifid_instruction is real (not a bubble)
redirect_pending  output  1  1 = buffered redirect awaiting pc_enable
misalign_err  output  1  sticky: a target with [1:0] != 00 was accepted
fetch_count  output  CNT_W  instructions loaded into IF/ID with valid=1
stall_count  output  CNT_W  cycles with pc_enable=0 while in RUN or PEND

Behaviour:
Reset (synchronous, applies at any state, including mid-stall or with a pending redirect):
- pc=RESET_PC, npc=RESET_PC+4
- ifid_instruction=0, ifid_pc=0, ifid_valid=0
- redirect_pending=0, misalign_err=0, both counters=0
- state=BOOT

FSM states:
- BOOT: one cycle only. No PC update, IF/ID outputs hold the bubble. Always -> RUN. branch_taken during BOOT is ignored.
- RUN, pc_enable=1, branch_taken=0: pc<=npc, npc<=npc+4.
- RUN, pc_enable=1, branch_taken=1: pc<=npc (delay slot), npc<={target_addr[31:2],2'b00}.
- RUN, pc_enable=0, branch_taken=1: hold pc/npc, capture target into pend_target, -> PEND.
- RUN, pc_enable=0, branch_taken=0: hold pc/npc.
- PEND, pc_enable=0: hold everything. A new branch_taken overwrites pend_target (latest wins).
- PEND, pc_enable=1: pc<=npc, npc<=pend_target, -> RUN. Any branch_taken in this cycle wins over pend_target.

Datapath rules:
- Address arithmetic is 32-bit modulo 2^32; 0xFFFFFFFC+4 wraps to 0x00000000.
- target_addr[1:0] is always forced to 00. misalign_err sets whenever a target with nonzero [1:0] is accepted (applied or captured into PEND). Cleared only by reset.

IF/ID update each cycle (not BOOT):
- load_enable=0: hold all IF/ID outputs (nop_signal ignored).
- load_enable=1, nop_signal=1: instruction=0, ifid_pc=pc, valid=0.
- load_enable=1, nop_signal=0: instruction=imem_data, ifid_pc=pc, valid=1, fetch_count++.

Outputs and counters:
- Latency: word at address pc appears on ifid_instruction one clock later.
- redirect_pending = (state==PEND).
- Both counters saturate at all-ones (no wrap).

Decomposition:
- Shared pipeline package holds: state encoding (BOOT/RUN/PEND, 2 bits), NOP_INSTR=32'h0, WORD_STEP=32'd4.
- One natural sub-module: fetch_pc_ctrl (PC/nPC registers, FSM, pending-target buffer).
- Top level adds the IF/ID output registers and the counters.

Test Plan:
1. Reset, imem[0]=A, imem[4]=B, all enables 1 -> cycle1 BOOT valid=0; cycle2 ifid=A, ifid_pc=0; cycle3 ifid=B; pc steps 0,4,8.
2. branch_taken with target 0x40 while pc=8, npc=12 -> next pc=12 (delay slot fetched), then pc=0x40, 0x44.
3. pc_enable=0 for 3 cycles, branch_taken target 0x80 in stall cycle 2 -> redirect_pending=1, pc/npc frozen, stall_count=3; on release pc=old npc, then 0x80.
4. load_enable=1, nop_signal=1 for one cycle -> ifid_instruction=0, valid=0, fetch_count unchanged; next cycle real word, valid=1.
5. target_addr=0x103 -> npc=0x100, misalign_err=1 and remains set until reset.
6. reset asserted while in PEND with pc=0x200 -> next edge pc=0, npc=4, redirect_pending=0, counters 0, state BOOT; npc=0xFFFFFFFC advancing -> npc=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM encoding and word-address constants.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] WORD_STEP = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Hazard, redirect, instruction-memory and IF/ID signals of the fetch stage.
interface fetch_stage_if #(
  parameter int IMEM_AW = 9,
  parameter int CNT_W   = 16
);
  logic               pc_enable;
  logic               load_enable;
  logic               nop_signal;
  logic               branch_taken;
  logic [31:0]        target_addr;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_data;
  logic [31:0]        pc;
  logic [31:0]        npc;
  logic [31:0]        ifid_instruction;
  logic [31:0]        ifid_pc;
  logic               ifid_valid;
  logic               redirect_pending;
  logic               misalign_err;
  logic [CNT_W-1:0]   fetch_count;
  logic [CNT_W-1:0]   stall_count;

  modport master (
    input  pc_enable, load_enable, nop_signal, branch_taken, target_addr, imem_data,
    output imem_addr, pc, npc, ifid_instruction, ifid_pc, ifid_valid,
           redirect_pending, misalign_err, fetch_count, stall_count
  );

  modport slave (
    output pc_enable, load_enable, nop_signal, branch_taken, target_addr, imem_data,
    input  imem_addr, pc, npc, ifid_instruction, ifid_pc, ifid_valid,
           redirect_pending, misalign_err, fetch_count, stall_count
  );
endinterface

// File: rtl/fetch_stage_pc_ctrl.sv
// PC/nPC pair with delay-slot sequencing and a one-deep buffer for redirects seen during a stall.
//   state | meaning
//   BOOT  | first cycle after reset, PC held, redirects ignored
//   RUN   | normal fetch, redirects applied to nPC immediately
//   PEND  | stalled with a redirect target buffered until pc_enable
module fetch_pc_ctrl
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pc_enable,
  input  logic         branch_taken,
  input  logic [31:0]  target_addr,
  output logic [31:0]  pc,
  output logic [31:0]  npc,
  output fetch_state_e state,
  output logic         redirect_pending,
  output logic         misalign_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  npc_q, npc_d;
  logic [31:0]  pend_target_q, pend_target_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  tgt_aligned;
  logic         tgt_misaligned;

  assign tgt_aligned    = word_align(target_addr);
  assign tgt_misaligned = (target_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      npc_q         <= RESET_PC + WORD_STEP;
      pend_target_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      npc_q         <= npc_d;
      pend_target_q <= pend_target_d;
      misalign_q    <= misalign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (!pc_enable && branch_taken) state_d = ST_PEND;
      ST_PEND: if (pc_enable) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // A redirect arriving on the release cycle is newer than the buffered one, so it wins.
  always_comb begin
    pc_d          = pc_q;
    npc_d         = npc_q;
    pend_target_d = pend_target_q;
    misalign_d    = misalign_q;
    case (state_q)
      ST_RUN: begin
        if (pc_enable) begin
          pc_d  = npc_q;
          npc_d = branch_taken ? tgt_aligned : npc_q + WORD_STEP;
        end else if (branch_taken) begin
          pend_target_d = tgt_aligned;
        end
        if (branch_taken && tgt_misaligned) misalign_d = 1'b1;
      end
      ST_PEND: begin
        if (pc_enable) begin
          pc_d  = npc_q;
          npc_d = branch_taken ? tgt_aligned : pend_target_q;
        end else if (branch_taken) begin
          pend_target_d = tgt_aligned;
        end
        if (branch_taken && tgt_misaligned) misalign_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc               = pc_q;
    npc              = npc_q;
    state            = state_q;
    redirect_pending = (state_q == ST_PEND);
    misalign_err     = misalign_q;
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC control, IF/ID output registers and saturating fetch/stall counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          IMEM_AW  = 9,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          CNT_W    = 16
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  logic [31:0]      pc, npc;
  fetch_state_e     state;
  logic             redirect_pending, misalign_err;
  logic [31:0]      ifid_instr_q, ifid_instr_d;
  logic [31:0]      ifid_pc_q, ifid_pc_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  fetch_pc_ctrl #(.RESET_PC(RESET_PC)) u_pc_ctrl (
    .clk              (clk),
    .reset            (reset),
    .pc_enable        (bus.pc_enable),
    .branch_taken     (bus.branch_taken),
    .target_addr      (bus.target_addr),
    .pc               (pc),
    .npc              (npc),
    .state            (state),
    .redirect_pending (redirect_pending),
    .misalign_err     (misalign_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_instr_q  <= NOP_INSTR;
      ifid_pc_q     <= '0;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  // BOOT leaves the reset bubble in IF/ID; counters stop at all-ones.
  always_comb begin
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (state != ST_BOOT) begin
      if (bus.load_enable) begin
        ifid_pc_d = pc;
        if (bus.nop_signal) begin
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else begin
          ifid_instr_d = bus.imem_data;
          ifid_valid_d = 1'b1;
          if (!(&fetch_count_q)) fetch_count_d = fetch_count_q + CNT_W'(1);
        end
      end
      if (!bus.pc_enable && !(&stall_count_q)) stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  assign bus.imem_addr        = pc[IMEM_AW-1:0];
  assign bus.pc               = pc;
  assign bus.npc              = npc;
  assign bus.ifid_instruction = ifid_instr_q;
  assign bus.ifid_pc          = ifid_pc_q;
  assign bus.ifid_valid       = ifid_valid_q;
  assign bus.redirect_pending = redirect_pending;
  assign bus.misalign_err     = misalign_err;
  assign bus.fetch_count      = fetch_count_q;
  assign bus.stall_count      = stall_count_q;

endmodule
